mod_delay_line: RTL and testbench

Modulated fractional delay line for the chorus/flanger path, directly downstream of the LFO generator. Each audio-rate strobe writes the incoming sample into a circular buffer. It then reads two adjacent taps at a delay of base delay plus LFO offset, and emits their linear interpolation. LFO wave and valid flag come straight from the LFO generator; the sample strobe is the same FIFO update strobe that drives the LFO.

---
 rtl/delay_pkg.sv | 26 ++
 rtl/mod_delay_line_if.sv | 23 ++
 rtl/delay_ram.sv | 22 ++
 rtl/mod_delay_line.sv | 159 +++++++++++++++
 tb/tb_mod_delay_line.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared widths, FSM encoding and saturation helper for the modulated delay line
package delay_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FRAC_W   = 8;
  localparam int Q_ONE    = 1 << FRAC_W;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WR   = 3'd1;
  localparam state_t ST_RD0  = 3'd2;
  localparam state_t ST_RD1  = 3'd3;
  localparam state_t ST_LAT  = 3'd4;
  localparam state_t ST_MIX  = 3'd5;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return $signed(v[15:0]);
  endfunction

endpackage

// File: rtl/mod_delay_line_if.sv
// rtl/mod_delay_line_if.sv - sample/LFO inputs and wet output bundle of the delay line
interface mod_delay_line_if;
  import delay_pkg::*;

  logic signed [SAMPLE_W-1:0] sample_i;
  logic                       FIFOupdate_i;
  logic signed [SAMPLE_W-1:0] lfo_i;
  logic                       lfoValid_i;
  logic signed [SAMPLE_W-1:0] sample_o;
  logic                       sampleValid_o;
  logic                       overrun_o;

  modport master (
    output sample_i, FIFOupdate_i, lfo_i, lfoValid_i,
    input  sample_o, sampleValid_o, overrun_o
  );

  modport slave (
    input  sample_i, FIFOupdate_i, lfo_i, lfoValid_i,
    output sample_o, sampleValid_o, overrun_o
  );

endinterface

// File: rtl/delay_ram.sv
// rtl/delay_ram.sv - simple dual-port sample buffer, one write port, registered read, no reset
module delay_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mod_delay_line.sv
// rtl/mod_delay_line.sv - LFO-modulated fractional delay line with linear tap interpolation
module mod_delay_line
  import delay_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int BASE_DLY = 256,
  parameter int MOD_GAIN = 128
) (
  input  logic            clk_i,
  input  logic            reset_i,
  mod_delay_line_if.slave bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DLY_LO = Q_ONE;
  localparam int DLY_HI = (DEPTH - 2) * Q_ONE;

  // 18 bits at the default settings; widens so a large BASE_DLY cannot wrap before the clamp
  localparam int DLY_W_REQ = $clog2(BASE_DLY * Q_ONE + 65536) + 1;
  localparam int DLY_W     = (DLY_W_REQ > 18) ? DLY_W_REQ : 18;

  localparam logic [7:0]              GAIN8   = 8'(MOD_GAIN);
  localparam logic signed [DLY_W-1:0] BASE_Q8 = DLY_W'(BASE_DLY * Q_ONE);

  state_t                      state;
  logic signed [SAMPLE_W-1:0]  lfo_q;
  logic signed [SAMPLE_W-1:0]  smp_q;
  logic [ADDR_W-1:0]           wr_ptr;
  logic [ADDR_W:0]             fill_cnt;
  logic [ADDR_W-1:0]           int_d;
  logic [FRAC_W-1:0]           frac;
  logic signed [SAMPLE_W-1:0]  tap_a;
  logic signed [SAMPLE_W-1:0]  tap_b;
  logic signed [SAMPLE_W-1:0]  sample_q;
  logic                        valid_q;
  logic                        overrun_q;

  logic signed [24:0]          lfo_prod;
  logic signed [DLY_W-1:0]     offset_q8;
  logic signed [DLY_W-1:0]     dly_raw;
  logic signed [31:0]          dly_ext;
  logic signed [31:0]          dly_sel;

  logic [ADDR_W-1:0]           raddr;
  logic [SAMPLE_W-1:0]         rdata;

  logic signed [SAMPLE_W-1:0]  a_g;
  logic signed [SAMPLE_W-1:0]  b_g;
  logic signed [16:0]          diff;
  logic signed [24:0]          prod;
  logic signed [17:0]          sum;
  logic signed [SAMPLE_W-1:0]  wet;

  assign lfo_prod  = lfo_q * $signed({1'b0, GAIN8});
  assign offset_q8 = DLY_W'(lfo_prod >>> 7);
  assign dly_raw   = BASE_Q8 + offset_q8;
  assign dly_ext   = 32'(dly_raw);

  always_comb begin
    dly_sel = dly_ext;
    if (dly_ext < DLY_LO)
      dly_sel = DLY_LO;
    else if (dly_ext > DLY_HI)
      dly_sel = DLY_HI;
  end

  // wr_ptr has already advanced past the newest sample by the time the taps are read
  always_comb begin
    raddr = wr_ptr - ADDR_W'(1) - int_d;
    if (state == ST_RD1)
      raddr = wr_ptr - ADDR_W'(2) - int_d;
  end

  delay_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (SAMPLE_W)
  ) u_ram (
    .clk   (clk_i),
    .we    (state == ST_WR),
    .waddr (wr_ptr),
    .wdata (smp_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  // taps older than the number of samples written since reset hold stale RAM contents
  always_comb begin
    a_g = '0;
    b_g = '0;
    if ((ADDR_W+1)'(int_d) < fill_cnt)
      a_g = tap_a;
    if ((ADDR_W+1)'(int_d) + (ADDR_W+1)'(1) < fill_cnt)
      b_g = tap_b;
    diff = {b_g[SAMPLE_W-1], b_g} - {a_g[SAMPLE_W-1], a_g};
    prod = diff * $signed({1'b0, frac});
    sum  = 18'(a_g) + 18'(prod >>> FRAC_W);
    wet  = sat16(sum);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      lfo_q     <= '0;
      smp_q     <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      int_d     <= '0;
      frac      <= '0;
      tap_a     <= '0;
      tap_b     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.lfoValid_i)
        lfo_q <= bus.lfo_i;
      valid_q <= 1'b0;
      if (bus.FIFOupdate_i && state != ST_IDLE)
        overrun_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.FIFOupdate_i) begin
            smp_q <= bus.sample_i;
            int_d <= ADDR_W'(dly_sel >>> FRAC_W);
            frac  <= dly_sel[FRAC_W-1:0];
            state <= ST_WR;
          end
        end
        ST_WR: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill_cnt != (ADDR_W+1)'(DEPTH))
            fill_cnt <= fill_cnt + 1'b1;
          state <= ST_RD0;
        end
        ST_RD0: state <= ST_RD1;
        ST_RD1: begin
          tap_a <= $signed(rdata);
          state <= ST_LAT;
        end
        ST_LAT: begin
          tap_b <= $signed(rdata);
          state <= ST_MIX;
        end
        ST_MIX: begin
          sample_q <= wet;
          valid_q  <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sample_o      = sample_q;
  assign bus.sampleValid_o = valid_q;
  assign bus.overrun_o     = overrun_q;

endmodule

// File: tb/tb_mod_delay_line.sv
// tb/tb_mod_delay_line.sv - directed bench for mod_delay_line across default and clamp-corner instances
module tb_mod_delay_line;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_delay_line_if bus0 ();
  mod_delay_line_if bus1 ();
  mod_delay_line_if bus2 ();

  mod_delay_line u0 (.clk_i(clk), .reset_i(rst), .bus(bus0));
  mod_delay_line #(.BASE_DLY(1000)) u1 (.clk_i(clk), .reset_i(rst), .bus(bus1));
  mod_delay_line #(.BASE_DLY(100), .MOD_GAIN(255)) u2 (.clk_i(clk), .reset_i(rst), .bus(bus2));

  int vectors = 0;
  int miscompares = 0;
  int pulses;
  logic signed [15:0] o0, o1, o2;
  logic signed [15:0] xs [0:2999];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic set_strobe(input logic v);
    bus0.FIFOupdate_i = v;
    bus1.FIFOupdate_i = v;
    bus2.FIFOupdate_i = v;
  endtask

  task automatic set_lfo(input logic signed [15:0] l0, l1, l2);
    bus0.lfo_i = l0; bus1.lfo_i = l1; bus2.lfo_i = l2;
    bus0.lfoValid_i = 1'b1; bus1.lfoValid_i = 1'b1; bus2.lfoValid_i = 1'b1;
    tick();
    bus0.lfoValid_i = 1'b0; bus1.lfoValid_i = 1'b0; bus2.lfoValid_i = 1'b0;
  endtask

  // one strobe on all instances, 8 clocks per slot; valid must appear only after edge 5
  task automatic strobe(input int idx, input logic signed [15:0] s,
                        output logic signed [15:0] r0, r1, r2);
    logic [7:0] pat;
    pat = '0;
    bus0.sample_i = s; bus1.sample_i = s; bus2.sample_i = s;
    set_strobe(1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) set_strobe(1'b0);
      pat[k] = bus0.sampleValid_o;
      if (k == 5) begin
        r0 = bus0.sample_o; r1 = bus1.sample_o; r2 = bus2.sample_o;
      end
    end
    check("valid_timing", idx, 32'(pat), 32'h20);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bus0.sample_i = '0; bus1.sample_i = '0; bus2.sample_i = '0;
    bus0.lfo_i = '0; bus1.lfo_i = '0; bus2.lfo_i = '0;
    bus0.lfoValid_i = 1'b0; bus1.lfoValid_i = 1'b0; bus2.lfoValid_i = 1'b0;
    set_strobe(1'b0);
    rst = 1'b1;
    repeat (5) tick();
    check("rst_sample", 0, bus0.sample_o, 0);
    check("rst_valid", 0, 32'(bus0.sampleValid_o), 0);
    check("rst_overrun", 0, 32'(bus0.overrun_o), 0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus0.sampleValid_o) pulses++;
    end
    check("idle_pulses", 0, pulses, 0);

    // integer delay on u0, high clamp (1022) on u1, low clamp (1) on u2
    set_lfo(16'sd0, 16'sd32767, -16'sd32768);
    for (int n = 0; n < 1030; n++) begin
      strobe(n, (n == 0) ? 16'sd1000 : 16'sd0, o0, o1, o2);
      check("int_dly", n, o0, (n == 256) ? 1000 : 0);
      check("clamp_hi", n, o1, (n == 1022) ? 1000 : 0);
      check("clamp_lo", n, o2, (n == 1) ? 1000 : 0);
    end

    // delay 256.5 on a 4n ramp
    pulse_reset();
    set_lfo(16'sd128, 16'sd0, 16'sd0);
    for (int n = 0; n < 300; n++) begin
      strobe(n, 16'(4 * n), o0, o1, o2);
      check("frac_dly", n, o0, (n >= 257) ? 4 * (n - 256) - 2 : 0);
    end
    // LFO update coinciding with a strobe takes effect one strobe later
    bus0.lfo_i = 16'sd0;
    bus0.lfoValid_i = 1'b1;
    strobe(300, 16'sd1200, o0, o1, o2);
    bus0.lfoValid_i = 1'b0;
    check("lfo_same_cycle", 300, o0, 4 * 44 - 2);
    strobe(301, 16'sd1204, o0, o1, o2);
    check("lfo_next", 301, o0, 4 * 45);

    // second strobe two clocks after the first is dropped
    pulse_reset();
    bus0.sample_i = 16'sd1000;
    bus0.FIFOupdate_i = 1'b1;
    tick();
    bus0.FIFOupdate_i = 1'b0;
    tick();
    bus0.sample_i = 16'sd555;
    bus0.FIFOupdate_i = 1'b1;
    tick();
    bus0.FIFOupdate_i = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      if (bus0.sampleValid_o) pulses++;
    end
    check("ovr_pulses", 0, pulses, 1);
    check("ovr_flag", 0, 32'(bus0.overrun_o), 1);
    for (int n = 1; n <= 257; n++) begin
      strobe(n, 16'sd0, o0, o1, o2);
      check("ovr_align", n, o0, (n == 256) ? 1000 : 0);
    end
    check("ovr_sticky", 0, 32'(bus0.overrun_o), 1);
    check("ovr_other", 0, 32'(bus1.overrun_o), 0);

    // long run across several wrPtr wraps
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      xs[n] = (n % 2 == 1) ? 16'(-(n * 7 + 1)) : 16'(n * 7 + 1);
      strobe(n, xs[n], o0, o1, o2);
      check("wrap", n, o0, (n >= 256) ? 32'(xs[n - 256]) : 0);
    end

    // reset while in RD1
    bus0.sample_i = 16'sd123;
    bus0.FIFOupdate_i = 1'b1;
    tick();
    bus0.FIFOupdate_i = 1'b0;
    tick();
    tick();
    check("pre_rst_hold", 0, bus0.sample_o, 32'(xs[2743]));
    rst = 1'b1;
    #1;
    check("mid_rst_sample", 0, bus0.sample_o, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (bus0.sampleValid_o) pulses++;
    end
    check("mid_rst_pulses", 0, pulses, 0);
    check("mid_rst_overrun", 0, 32'(bus0.overrun_o), 0);
    // stale RAM must stay gated once fill count restarts
    strobe(0, 16'sd5, o0, o1, o2);
    check("post_rst_gate", 0, o0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
